// File: rtl/game_pkg.sv
// Shared game geometry and the hit-controller FSM states; the dragon mover uses the same bounds.
package game_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int D_W      = 40;
  localparam int D_H      = 40;
  localparam int B_W      = 8;
  localparam int B_H      = 4;

  typedef enum logic [1:0] {ST_ARMED, ST_KILLED, ST_DEAD} hit_state_e;
endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD counter with increment enable; saturates and holds at 9999.
module bcd_counter4 (
  input  logic        clk_22,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] value
);
  logic [15:0] nxt;
  logic        carry;

  // Ripple carry: each digit wraps 9->0 and passes the carry upward.
  always_comb begin
    nxt   = value;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (value[i*4 +: 4] == 4'd9) begin
          nxt[i*4 +: 4] = 4'd0;
        end else begin
          nxt[i*4 +: 4] = value[i*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_22 or negedge rst)
    if (!rst)                             value <= 16'h0000;
    else if (inc && value != 16'h9999)    value <= nxt;
endmodule

// File: rtl/dragon_hit_ctrl.sv
// Player bullet manager and dragon hit detector; drives the mover's life_state kill pulse.
module dragon_hit_ctrl
  import game_pkg::*;
#(
  parameter int NUM_B    = 4,
  parameter int B_SPEED  = 8,
  parameter int COOLDOWN = 4
) (
  input  logic                 clk_22,
  input  logic                 rst,
  input  logic                 fire,
  input  logic [9:0]           p_x,
  input  logic [9:0]           p_y,
  input  logic [9:0]           d_x,
  input  logic [9:0]           d_y,
  input  logic                 d_valid,
  output logic                 life_state,
  output logic [10*NUM_B-1:0]  b_x,
  output logic [10*NUM_B-1:0]  b_y,
  output logic [NUM_B-1:0]     b_valid,
  output logic [15:0]          score
);
  localparam int          CW    = $clog2(COOLDOWN + 1);
  localparam logic [10:0] DW11  = 11'(D_W);
  localparam logic [10:0] DH11  = 11'(D_H);
  localparam logic [10:0] BW11  = 11'(B_W);
  localparam logic [10:0] BH11  = 11'(B_H);
  localparam logic [10:0] SPD11 = 11'(B_SPEED);
  localparam logic [10:0] SCR11 = 11'(SCREEN_W);

  logic [NUM_B-1:0][9:0] bx_r, by_r;
  logic [NUM_B-1:0]      bv_r, hit, free_sel;
  logic [CW-1:0]         cd;
  logic                  fire_q, fire_edge, launch, any_hit, taken;
  hit_state_e            state;

  logic [10:0] dx11, dy11;
  assign dx11 = {1'b0, d_x};
  assign dy11 = {1'b0, d_y};

  // Lowest-index free slot, from occupancy before this tick's update.
  always_comb begin
    free_sel = '0;
    taken    = 1'b0;
    for (int i = 0; i < NUM_B; i++) begin
      free_sel[i] = ~bv_r[i] & ~taken;
      taken       = taken | ~bv_r[i];
    end
  end

  assign fire_edge = fire & ~fire_q;
  assign launch    = fire_edge & (cd == '0) & ~(&bv_r);
  assign any_hit   = |hit;

  for (genvar i = 0; i < NUM_B; i++) begin : g_slot
    logic        v;
    logic [9:0]  x, y;
    logic [10:0] bx11, by11, nx;
    logic        overlap;

    assign bx11    = {1'b0, x};
    assign by11    = {1'b0, y};
    assign nx      = bx11 + SPD11;
    assign overlap = (bx11 < dx11 + DW11) && (bx11 + BW11 > dx11) &&
                     (by11 < dy11 + DH11) && (by11 + BH11 > dy11);
    assign hit[i]  = (state == ST_ARMED) & d_valid & v & overlap;

    always_ff @(posedge clk_22 or negedge rst)
      if (!rst) begin
        v <= 1'b0;
        x <= '0;
        y <= '0;
      end else if (v) begin
        if (hit[i] || nx >= SCR11) v <= 1'b0;
        else                       x <= nx[9:0];
      end else if (launch && free_sel[i]) begin
        v <= 1'b1;
        x <= p_x;
        y <= p_y;
      end

    assign bv_r[i] = v;
    assign bx_r[i] = x;
    assign by_r[i] = y;
  end

  assign b_x     = bx_r;
  assign b_y     = by_r;
  assign b_valid = bv_r;

  // fire_q resets high so a button held through reset does not shoot.
  always_ff @(posedge clk_22 or negedge rst)
    if (!rst) begin
      fire_q     <= 1'b1;
      cd         <= '0;
      state      <= ST_ARMED;
      life_state <= 1'b0;
    end else begin
      fire_q     <= fire;
      life_state <= 1'b0;
      if (launch)          cd <= CW'(COOLDOWN);
      else if (cd != '0)   cd <= cd - CW'(1);
      case (state)
        ST_ARMED:  if (any_hit) begin
                     state      <= ST_KILLED;
                     life_state <= 1'b1;
                   end
        ST_KILLED: if (!d_valid) state <= ST_DEAD;
        ST_DEAD:   if (d_valid)  state <= ST_ARMED;
        default:   state <= ST_ARMED;
      endcase
    end

  bcd_counter4 u_score (
    .clk_22 (clk_22),
    .rst    (rst),
    .inc    (any_hit),
    .value  (score)
  );
endmodule

// File: tb/tb_dragon_hit_ctrl.sv
// Directed-vector bench for dragon_hit_ctrl plus a standalone check of the BCD score counter.
module tb_dragon_hit_ctrl;
  logic        clk_22 = 1'b0;
  logic        rst, fire, d_valid, life_state, cinc;
  logic [9:0]  p_x, p_y, d_x, d_y;
  logic [39:0] b_x, b_y;
  logic [3:0]  b_valid;
  logic [15:0] score, cval;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_22 = ~clk_22;

  dragon_hit_ctrl dut (
    .clk_22(clk_22), .rst(rst), .fire(fire), .p_x(p_x), .p_y(p_y),
    .d_x(d_x), .d_y(d_y), .d_valid(d_valid), .life_state(life_state),
    .b_x(b_x), .b_y(b_y), .b_valid(b_valid), .score(score)
  );

  bcd_counter4 u_cnt (.clk_22(clk_22), .rst(rst), .inc(cinc), .value(cval));

  task automatic tick();
    @(posedge clk_22);
    #1;
  endtask

  task automatic do_reset();
    fire = 1'b0;
    rst  = 1'b0;
    #2;
    rst  = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; fire = 1'b1; cinc = 1'b0; d_valid = 1'b0;
    p_x = '0; p_y = '0; d_x = '0; d_y = '0;
    #2;
    checks++;
    if ({life_state, b_valid, b_x, b_y, score} !== '0) begin
      errors++;
      $display("FAIL reset_state: got life=%b v=%b x=%h y=%h score=%h want all zero",
               life_state, b_valid, b_x, b_y, score);
    end
    #10 rst = 1'b1;
    tick(); tick();
    // fire was high through reset: no shot
    checks++;
    if (b_valid !== 4'b0000) begin
      errors++;
      $display("FAIL reset_held_fire: got v=%b want 0000", b_valid);
    end
    fire = 1'b0;
    tick();
  endtask

  task automatic test_launch_fly();
    p_x = 10'd100; p_y = 10'd200;
    fire = 1'b1; tick(); fire = 1'b0;
    checks++;
    if (b_valid !== 4'b0001 || b_x[9:0] !== 10'd100 || b_y[9:0] !== 10'd200) begin
      errors++;
      $display("FAIL launch_pos: got v=%b x=%0d y=%0d want v=0001 x=100 y=200",
               b_valid, b_x[9:0], b_y[9:0]);
    end
    tick();
    checks++;
    if (b_x[9:0] !== 10'd108) begin
      errors++;
      $display("FAIL move_1: got x=%0d want 108", b_x[9:0]);
    end
    tick();
    checks++;
    if (b_x[9:0] !== 10'd116) begin
      errors++;
      $display("FAIL move_2: got x=%0d want 116", b_x[9:0]);
    end
    repeat (65) tick();
    checks++;
    if (b_valid !== 4'b0001 || b_x[9:0] !== 10'd636) begin
      errors++;
      $display("FAIL edge_last: got v=%b x=%0d want v=0001 x=636", b_valid, b_x[9:0]);
    end
    tick();
    checks++;
    if (b_valid !== 4'b0000) begin
      errors++;
      $display("FAIL edge_exit: got v=%b want 0000", b_valid);
    end
  endtask

  task automatic test_held_fire();
    do_reset();
    fire = 1'b1;
    repeat (10) tick();
    fire = 1'b0;
    checks++;
    if (b_valid !== 4'b0001 || b_x[9:0] !== 10'd172) begin
      errors++;
      $display("FAIL held_fire: got v=%b x0=%0d want v=0001 x0=172", b_valid, b_x[9:0]);
    end
  endtask

  task automatic test_four_slots();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fire = 1'b1; tick(); fire = 1'b0;
      if (k == 3) begin
        checks++;
        if (b_valid !== 4'b1111 || b_x[39:30] !== 10'd100 || b_x[9:0] !== 10'd220) begin
          errors++;
          $display("FAIL four_slots: got v=%b x3=%0d x0=%0d want v=1111 x3=100 x0=220",
                   b_valid, b_x[39:30], b_x[9:0]);
        end
      end
      repeat (4) tick();
    end
    fire = 1'b1; tick(); fire = 1'b0;
    checks++;
    if (b_valid !== 4'b1111 || b_x[39:30] !== 10'd140 || b_x[9:0] !== 10'd260) begin
      errors++;
      $display("FAIL fifth_edge: got v=%b x3=%0d x0=%0d want v=1111 x3=140 x0=260",
               b_valid, b_x[39:30], b_x[9:0]);
    end
  endtask

  task automatic test_cooldown();
    do_reset();
    fire = 1'b1; tick();
    fire = 1'b0; tick();
    fire = 1'b1; tick();
    fire = 1'b0;
    repeat (3) tick();
    checks++;
    if (b_valid !== 4'b0001) begin
      errors++;
      $display("FAIL cooldown_drop: got v=%b want 0001", b_valid);
    end
  endtask

  task automatic test_hit();
    do_reset();
    d_x = 10'd300; d_y = 10'd200; d_valid = 1'b1;
    p_x = 10'd260; p_y = 10'd210;
    fire = 1'b1; tick(); fire = 1'b0;
    repeat (4) tick();
    checks++;
    if (life_state !== 1'b0 || b_valid !== 4'b0001 || b_x[9:0] !== 10'd292) begin
      errors++;
      $display("FAIL hit_pre: got life=%b v=%b x=%0d want life=0 v=0001 x=292",
               life_state, b_valid, b_x[9:0]);
    end
    tick();
    checks++;
    if (life_state !== 1'b0 || b_valid !== 4'b0001 || b_x[9:0] !== 10'd300) begin
      errors++;
      $display("FAIL hit_overlap: got life=%b v=%b x=%0d want life=0 v=0001 x=300",
               life_state, b_valid, b_x[9:0]);
    end
    tick();
    checks++;
    if (life_state !== 1'b1 || b_valid !== 4'b0000 || score !== 16'h0001) begin
      errors++;
      $display("FAIL hit_pulse: got life=%b v=%b score=%h want life=1 v=0000 score=0001",
               life_state, b_valid, score);
    end
    tick();
    checks++;
    if (life_state !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse_end: got life=%b want 0", life_state);
    end
  endtask

  task automatic test_multi_hit();
    d_valid = 1'b0; tick();
    p_x = 10'd100; p_y = 10'd210;
    fire = 1'b1; tick(); fire = 1'b0;
    repeat (4) tick();
    fire = 1'b1; tick(); fire = 1'b0;
    d_x = 10'd109; d_y = 10'd200; d_valid = 1'b1;
    tick();
    checks++;
    if (life_state !== 1'b0 || b_valid !== 4'b0011 || b_x[9:0] !== 10'd148 || b_x[19:10] !== 10'd108) begin
      errors++;
      $display("FAIL multi_pre: got life=%b v=%b x0=%0d x1=%0d want life=0 v=0011 x0=148 x1=108",
               life_state, b_valid, b_x[9:0], b_x[19:10]);
    end
    tick();
    checks++;
    if (life_state !== 1'b1 || b_valid !== 4'b0000 || score !== 16'h0002) begin
      errors++;
      $display("FAIL multi_hit: got life=%b v=%b score=%h want life=1 v=0000 score=0002",
               life_state, b_valid, score);
    end
  endtask

  task automatic test_kill_lockout();
    logic pulsed;
    repeat (4) tick();
    fire = 1'b1; tick(); fire = 1'b0;
    pulsed = 1'b0;
    repeat (8) begin
      tick();
      if (life_state) pulsed = 1'b1;
    end
    checks++;
    if (pulsed !== 1'b0 || b_valid !== 4'b0001 || b_x[9:0] !== 10'd164 || score !== 16'h0002) begin
      errors++;
      $display("FAIL lockout: got pulsed=%b v=%b x0=%0d score=%h want pulsed=0 v=0001 x0=164 score=0002",
               pulsed, b_valid, b_x[9:0], score);
    end
    d_valid = 1'b0; tick();
    d_valid = 1'b1; tick();
    fire = 1'b1; tick(); fire = 1'b0;
    tick();
    checks++;
    if (life_state !== 1'b0 || b_x[19:10] !== 10'd108 || b_valid !== 4'b0011) begin
      errors++;
      $display("FAIL rearm_pre: got life=%b v=%b x1=%0d want life=0 v=0011 x1=108",
               life_state, b_valid, b_x[19:10]);
    end
    tick();
    checks++;
    if (life_state !== 1'b1 || b_valid !== 4'b0001 || score !== 16'h0003) begin
      errors++;
      $display("FAIL rearm_hit: got life=%b v=%b score=%h want life=1 v=0001 score=0003",
               life_state, b_valid, score);
    end
  endtask

  task automatic test_reset_midflight();
    fire = 1'b1;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({life_state, b_valid, b_x, b_y, score} !== '0) begin
      errors++;
      $display("FAIL midflight_reset: got life=%b v=%b x=%h y=%h score=%h want all zero",
               life_state, b_valid, b_x, b_y, score);
    end
    #2 rst = 1'b1;
    tick(); tick();
    checks++;
    if (b_valid !== 4'b0000) begin
      errors++;
      $display("FAIL midflight_held_fire: got v=%b want 0000", b_valid);
    end
    fire = 1'b0;
  endtask

  task automatic test_bcd_saturate();
    logic [15:0] exp_v;
    logic        do_chk;
    cinc = 1'b1;
    for (int k = 1; k <= 10005; k++) begin
      tick();
      do_chk = 1'b1;
      case (k)
        9:       exp_v = 16'h0009;
        10:      exp_v = 16'h0010;
        99:      exp_v = 16'h0099;
        100:     exp_v = 16'h0100;
        1000:    exp_v = 16'h1000;
        9999:    exp_v = 16'h9999;
        10005:   exp_v = 16'h9999;
        default: begin exp_v = 16'h0000; do_chk = 1'b0; end
      endcase
      if (do_chk) begin
        checks++;
        if (cval !== exp_v) begin
          errors++;
          $display("FAIL bcd_count_%0d: got %h want %h", k, cval, exp_v);
        end
      end
    end
    cinc = 1'b0;
  endtask

  initial begin
    test_reset();
    test_launch_fly();
    test_held_fire();
    test_four_slots();
    test_cooldown();
    test_hit();
    test_multi_hit();
    test_kill_lockout();
    test_reset_midflight();
    test_bcd_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
